// File: rtl/weight_updater_pkg.sv
// Shared Q-format constants, FSM state encoding and the saturation helper
// used by the weight updater.
package weight_updater_pkg;

   localparam int unsigned DEF_FIXED_BITS      = 8;
   localparam int unsigned DEF_FRACTIONAL_BITS = 8;
   localparam int unsigned DEF_NUM_WEIGHTS     = 8;
   localparam int unsigned SAT_BITS            = 64;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ   = 3'd1,
      ST_WAIT  = 3'd2,
      ST_CALC  = 3'd3,
      ST_WRITE = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

   // Clamp a wide signed value into the signed range of a w-bit word.
   function automatic logic signed [SAT_BITS-1:0] sat_to_w(
      input logic signed [SAT_BITS-1:0] n,
      input int unsigned                w
   );
      logic signed [SAT_BITS-1:0] one;
      logic signed [SAT_BITS-1:0] max_v;
      logic signed [SAT_BITS-1:0] min_v;
      one   = SAT_BITS'(1);
      max_v = (one <<< (w - 1)) - one;
      min_v = -(one <<< (w - 1));
      if (n > max_v) begin
         return max_v;
      end else if (n < min_v) begin
         return min_v;
      end
      return n;
   endfunction

endpackage

// File: rtl/weight_updater_q_mul_shift.sv
// Signed Q-format multiply followed by an arithmetic (floor) right shift
// that drops the fractional bits of the product.
module q_mul_shift
   import weight_updater_pkg::*;
#(
   parameter int unsigned W               = DEF_FIXED_BITS + DEF_FRACTIONAL_BITS,
   parameter int unsigned FRACTIONAL_BITS = DEF_FRACTIONAL_BITS
) (
   input  logic signed [W-1:0]                 a,
   input  logic signed [W-1:0]                 b,
   output logic signed [W+FRACTIONAL_BITS-1:0] s
);

   logic signed [2*W-1:0] p;

   assign p = (2*W)'(a) * (2*W)'(b);
   assign s = (W+FRACTIONAL_BITS)'(p >>> FRACTIONAL_BITS);

endmodule

// File: rtl/weight_updater.sv
// Sequential SGD weight updater: walks every weight, fetches its gradient,
// applies w <= sat(w - lr*grad) and clears the gradient entry.
module weight_updater
   import weight_updater_pkg::*;
#(
   parameter  int unsigned FIXED_BITS      = DEF_FIXED_BITS,
   parameter  int unsigned FRACTIONAL_BITS = DEF_FRACTIONAL_BITS,
   parameter  int unsigned NUM_WEIGHTS     = DEF_NUM_WEIGHTS,
   localparam int unsigned W = FIXED_BITS + FRACTIONAL_BITS,
   localparam int unsigned A = (NUM_WEIGHTS > 1) ? $clog2(NUM_WEIGHTS) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic signed [W-1:0] lr,
   output logic                grad_req,
   output logic [A-1:0]        grad_addr,
   input  logic                grad_valid,
   input  logic signed [W-1:0] grad_data,
   output logic                grad_clear_en,
   output logic [A-1:0]        grad_clear_addr,
   input  logic                w_wr_en,
   input  logic [A-1:0]        w_wr_addr,
   input  logic signed [W-1:0] w_wr_data,
   input  logic [A-1:0]        w_rd_addr,
   output logic signed [W-1:0] w_rd_data,
   output logic                busy,
   output logic                done,
   output logic                sat_flag
);

   localparam int unsigned SW = W + FRACTIONAL_BITS;
   localparam int unsigned NW = W + FRACTIONAL_BITS + 1;
   localparam logic [A-1:0] LAST_IDX = A'(NUM_WEIGHTS - 1);

   state_t              state;
   state_t              state_nxt;
   logic [A-1:0]        idx;
   logic [A-1:0]        idx_nxt;
   logic signed [W-1:0] lr_q;
   logic signed [W-1:0] grad_q;
   logic signed [W-1:0] n_sat_q;
   logic signed [W-1:0] weights [NUM_WEIGHTS];

   logic signed [SW-1:0]       s_c;
   logic signed [W-1:0]        cur_w_c;
   logic signed [NW-1:0]       n_c;
   logic signed [SAT_BITS-1:0] n_wide_c;
   logic signed [SAT_BITS-1:0] sat_wide_c;
   logic signed [W-1:0]        n_sat_c;
   logic                       sat_c;

   logic                wr_en_c;
   logic [A-1:0]        wr_addr_c;
   logic signed [W-1:0] wr_data_c;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
      end
   end

   // Next-state and index sequencing
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      unique case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt = ST_REQ;
               idx_nxt   = '0;
            end
         end
         ST_REQ:  state_nxt = ST_WAIT;
         ST_WAIT: begin
            if (grad_valid) begin
               state_nxt = ST_CALC;
            end
         end
         ST_CALC: state_nxt = ST_WRITE;
         ST_WRITE: begin
            if (idx == LAST_IDX) begin
               state_nxt = ST_DONE;
            end else begin
               state_nxt = ST_REQ;
               idx_nxt   = idx + A'(1);
            end
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Strobes are registered from the upcoming state so they align with it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grad_req        <= 1'b0;
         grad_addr       <= '0;
         grad_clear_en   <= 1'b0;
         grad_clear_addr <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
      end else begin
         grad_req      <= (state_nxt == ST_REQ);
         grad_clear_en <= (state_nxt == ST_WRITE);
         busy          <= (state_nxt != ST_IDLE);
         done          <= (state_nxt == ST_DONE);
         if (state_nxt == ST_REQ) begin
            grad_addr <= idx_nxt;
         end
         if (state_nxt == ST_WRITE) begin
            grad_clear_addr <= idx_nxt;
         end
      end
   end

   q_mul_shift #(
      .W               (W),
      .FRACTIONAL_BITS (FRACTIONAL_BITS)
   ) u_mul (
      .a (lr_q),
      .b (grad_q),
      .s (s_c)
   );

   // Subtraction is wide enough that only the final clamp can overflow
   always_comb begin
      cur_w_c    = weights[idx];
      n_c        = NW'(cur_w_c) - NW'(s_c);
      n_wide_c   = SAT_BITS'(n_c);
      sat_wide_c = sat_to_w(n_wide_c, W);
      n_sat_c    = W'(sat_wide_c);
      sat_c      = (sat_wide_c != n_wide_c);
   end

   // Datapath registers: latched lr, captured gradient, clamped result, sticky flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lr_q     <= '0;
         grad_q   <= '0;
         n_sat_q  <= '0;
         sat_flag <= 1'b0;
      end else begin
         if (state == ST_IDLE && start) begin
            lr_q     <= lr;
            sat_flag <= 1'b0;
         end
         if (state == ST_WAIT && grad_valid) begin
            grad_q <= grad_data;
         end
         if (state == ST_CALC) begin
            n_sat_q <= n_sat_c;
            if (sat_c) begin
               sat_flag <= 1'b1;
            end
         end
      end
   end

   // Single weight write port shared by the update pass and the idle load port
   always_comb begin
      wr_en_c   = 1'b0;
      wr_addr_c = w_wr_addr;
      wr_data_c = w_wr_data;
      if (state == ST_WRITE) begin
         wr_en_c   = 1'b1;
         wr_addr_c = idx;
         wr_data_c = n_sat_q;
      end else if (state == ST_IDLE && w_wr_en && (32'(w_wr_addr) < NUM_WEIGHTS)) begin
         wr_en_c = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(NUM_WEIGHTS); i++) begin
            weights[i] <= '0;
         end
      end else if (wr_en_c) begin
         weights[wr_addr_c] <= wr_data_c;
      end
   end

   assign w_rd_data = (32'(w_rd_addr) < NUM_WEIGHTS) ? weights[w_rd_addr] : '0;

endmodule

// File: tb/tb_weight_updater.sv
// Directed bench for weight_updater (Q8.8, 8 weights) with hand-computed
// update results, strobe ordering, done timing, saturation and reset abort.
module tb_weight_updater;

   localparam int unsigned W = 16;
   localparam int unsigned A = 3;
   localparam int unsigned N = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] lr = '0;
   logic         grad_req;
   logic [A-1:0] grad_addr;
   logic         grad_valid = 1'b0;
   logic [W-1:0] grad_data = '0;
   logic         grad_clear_en;
   logic [A-1:0] grad_clear_addr;
   logic         w_wr_en = 1'b0;
   logic [A-1:0] w_wr_addr = '0;
   logic [W-1:0] w_wr_data = '0;
   logic [A-1:0] w_rd_addr = '0;
   logic [W-1:0] w_rd_data;
   logic         busy;
   logic         done;
   logic         sat_flag;

   int n_checks = 0;
   int n_fail   = 0;

   logic [W-1:0] gvals [N];
   int start_poke = -1;
   int wr_poke    = -1;
   int abort_cyc  = -1;
   int slow_idx   = -1;
   int slow_delay = 1;
   bit noise      = 1'b0;
   int nreq;
   int nclr;

   weight_updater dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .start           (start),
      .lr              (lr),
      .grad_req        (grad_req),
      .grad_addr       (grad_addr),
      .grad_valid      (grad_valid),
      .grad_data       (grad_data),
      .grad_clear_en   (grad_clear_en),
      .grad_clear_addr (grad_clear_addr),
      .w_wr_en         (w_wr_en),
      .w_wr_addr       (w_wr_addr),
      .w_wr_data       (w_wr_data),
      .w_rd_addr       (w_rd_addr),
      .w_rd_data       (w_rd_data),
      .busy            (busy),
      .done            (done),
      .sat_flag        (sat_flag)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic write_w(input logic [A-1:0] addr, input logic [W-1:0] data);
      @(negedge clk);
      w_wr_en   = 1'b1;
      w_wr_addr = addr;
      w_wr_data = data;
      @(negedge clk);
      w_wr_en   = 1'b0;
   endtask

   task automatic read_check(input string tag, input logic [A-1:0] addr, input logic [W-1:0] exp);
      w_rd_addr = addr;
      #1;
      check_val(tag, 32'(w_rd_data), 32'(exp));
   endtask

   // One update pass with a gradient responder; cycle 1 is the cycle after the start edge
   task automatic run_pass(input logic [W-1:0] lr_v, input int exp_done,
                           output int req_cnt, output int clr_cnt);
      int valid_cyc;
      int done_cyc;
      logic [A-1:0] cur;
      req_cnt   = 0;
      clr_cnt   = 0;
      valid_cyc = -10;
      done_cyc  = -1;
      cur       = '0;
      @(negedge clk);
      start = 1'b1;
      lr    = lr_v;
      @(negedge clk);
      start = 1'b0;
      lr    = '0;
      for (int cyc = 1; cyc <= 200; cyc++) begin
         if (cyc == abort_cyc) begin
            rst_n = 1'b0;
            break;
         end
         if (cyc == 1) begin
            check_val("busy_after_start", 32'(busy), 32'd1);
            check_val("sat_cleared_on_start", 32'(sat_flag), 32'd0);
         end
         if (grad_req) begin
            check_val("req_addr_order", 32'(grad_addr), 32'(req_cnt));
            cur       = grad_addr;
            valid_cyc = cyc + ((int'(grad_addr) == slow_idx) ? slow_delay : 1);
            req_cnt++;
         end
         if (grad_clear_en) begin
            check_val("clr_addr_order", 32'(grad_clear_addr), 32'(clr_cnt));
            clr_cnt++;
         end
         if (done) begin
            done_cyc = cyc;
            break;
         end
         grad_valid = (cyc == valid_cyc) || (noise && cyc == valid_cyc + 1);
         grad_data  = (cyc == valid_cyc) ? gvals[cur] : 16'h7FFF;
         start      = (cyc == start_poke);
         w_wr_en    = (cyc == wr_poke);
         w_wr_addr  = 3'd3;
         w_wr_data  = 16'hAAAA;
         @(negedge clk);
      end
      grad_valid = 1'b0;
      start      = 1'b0;
      w_wr_en    = 1'b0;
      if (abort_cyc < 0) begin
         check_val("done_cycle", 32'(done_cyc), 32'(exp_done));
         @(negedge clk);
         check_val("done_single_pulse", 32'(done), 32'd0);
         check_val("idle_after_done", 32'(busy), 32'd0);
      end
   endtask

   initial begin
      for (int i = 0; i < int'(N); i++) gvals[i] = '0;

      // Reset state
      #12;
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_done", 32'(done), 32'd0);
      check_val("rst_grad_req", 32'(grad_req), 32'd0);
      check_val("rst_clear_en", 32'(grad_clear_en), 32'd0);
      check_val("rst_grad_addr", 32'(grad_addr), 32'd0);
      check_val("rst_clear_addr", 32'(grad_clear_addr), 32'd0);
      check_val("rst_sat", 32'(sat_flag), 32'd0);
      read_check("rst_w0", 3'd0, 16'h0000);
      read_check("rst_w7", 3'd7, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;

      // Pass A: lr=0.5, mixed vectors, mid-pass start/write pokes and stray grad_valid
      write_w(3'd0, 16'h0100); gvals[0] = 16'h0100;
      write_w(3'd1, 16'h0200); gvals[1] = 16'h0200;
      write_w(3'd2, 16'h0000); gvals[2] = 16'hFFFF;
      write_w(3'd3, 16'h1000); gvals[3] = 16'h0000;
      write_w(3'd4, 16'hFF00); gvals[4] = 16'h0200;
      write_w(3'd5, 16'h0000); gvals[5] = 16'h8000;
      write_w(3'd6, 16'h8000); gvals[6] = 16'hFFFE;
      write_w(3'd7, 16'h7FFF); gvals[7] = 16'h0001;
      start_poke = 10; wr_poke = 5; noise = 1'b1;
      run_pass(16'h0080, 33, nreq, nclr);
      check_val("a_req_count", 32'(nreq), 32'd8);
      check_val("a_clr_count", 32'(nclr), 32'd8);
      check_val("a_sat", 32'(sat_flag), 32'd0);
      read_check("a_w0", 3'd0, 16'h0080);
      read_check("a_w1", 3'd1, 16'h0100);
      read_check("a_w2_floor", 3'd2, 16'h0001);
      read_check("a_w3_busy_write_ignored", 3'd3, 16'h1000);
      read_check("a_w4", 3'd4, 16'hFE00);
      read_check("a_w5", 3'd5, 16'h4000);
      read_check("a_w6", 3'd6, 16'h8001);
      read_check("a_w7", 3'd7, 16'h7FFF);

      // Pass B: positive saturation on idx 0, slow gradient on idx 3
      start_poke = -1; wr_poke = -1; noise = 1'b0;
      slow_idx = 3; slow_delay = 5;
      write_w(3'd0, 16'h7F00);
      for (int i = 0; i < int'(N); i++) gvals[i] = '0;
      gvals[0] = 16'h8000;
      run_pass(16'h0100, 37, nreq, nclr);
      check_val("b_req_count", 32'(nreq), 32'd8);
      check_val("b_sat", 32'(sat_flag), 32'd1);
      read_check("b_w0_sat_max", 3'd0, 16'h7FFF);
      read_check("b_w1_unchanged", 3'd1, 16'h0100);
      repeat (3) @(negedge clk);
      check_val("b_sat_sticky", 32'(sat_flag), 32'd1);

      // Pass C: negative saturation on idx 6; flag cleared at start then set again
      slow_idx = -1; slow_delay = 1;
      for (int i = 0; i < int'(N); i++) gvals[i] = '0;
      gvals[6] = 16'h0100;
      run_pass(16'h0100, 33, nreq, nclr);
      check_val("c_sat", 32'(sat_flag), 32'd1);
      read_check("c_w6_sat_min", 3'd6, 16'h8000);
      read_check("c_w0_unchanged", 3'd0, 16'h7FFF);

      // Pass D: reset while waiting for idx 2, then a clean full pass
      gvals[0] = 16'h0100; gvals[1] = 16'h0100;
      abort_cyc = 10;
      run_pass(16'h0080, 0, nreq, nclr);
      #1;
      check_val("abort_busy", 32'(busy), 32'd0);
      check_val("abort_grad_req", 32'(grad_req), 32'd0);
      check_val("abort_clear_en", 32'(grad_clear_en), 32'd0);
      check_val("abort_done", 32'(done), 32'd0);
      read_check("abort_w0", 3'd0, 16'h0000);
      read_check("abort_w1", 3'd1, 16'h0000);
      read_check("abort_w7", 3'd7, 16'h0000);
      repeat (2) @(negedge clk);
      check_val("abort_no_done", 32'(done), 32'd0);
      rst_n = 1'b1;
      abort_cyc = -1;
      write_w(3'd0, 16'h0100);
      for (int i = 0; i < int'(N); i++) gvals[i] = '0;
      gvals[0] = 16'h0100;
      run_pass(16'h0080, 33, nreq, nclr);
      check_val("d_req_count", 32'(nreq), 32'd8);
      check_val("d_clr_count", 32'(nclr), 32'd8);
      read_check("d_w0", 3'd0, 16'h0080);
      check_val("d_sat", 32'(sat_flag), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
